// File: rtl/ds_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ds_operand_stage_if
// Brief    : Bundle of fetch-side, regfile, forwarding and execute-side
//            signals around the decode/operand-read stage.
//            master = surrounding pipeline, slave = ds_operand_stage.
// Revision : 1.0 - initial release
// ============================================================================
interface ds_operand_stage_if #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int PAYLOAD_W = 64
);
  localparam int AW = $clog2(NREG);

  // Fetch -> decode
  logic                 fs_valid;
  logic                 ds_allow_in;
  logic [PAYLOAD_W-1:0] fs_payload;
  logic [AW-1:0]        fs_rj;
  logic [AW-1:0]        fs_rk;
  logic                 fs_use_rj;
  logic                 fs_use_rk;

  // Regfile read port
  logic [AW-1:0]        rf_raddr1;
  logic [AW-1:0]        rf_raddr2;
  logic [XLEN-1:0]      rf_rdata1;
  logic [XLEN-1:0]      rf_rdata2;

  // Forwarding sources, nearest stage first
  logic                 es_fwd_valid;
  logic [AW-1:0]        es_fwd_dest;
  logic                 es_fwd_is_load;
  logic [XLEN-1:0]      es_fwd_data;
  logic                 ms_fwd_valid;
  logic [AW-1:0]        ms_fwd_dest;
  logic                 ms_fwd_data_ok;
  logic [XLEN-1:0]      ms_fwd_data;
  logic                 ws_fwd_valid;
  logic [AW-1:0]        ws_fwd_dest;
  logic [XLEN-1:0]      ws_fwd_data;

  // Decode -> execute
  logic                 es_allow_in;
  logic                 flush;
  logic                 ds_to_es_valid;
  logic [PAYLOAD_W-1:0] ds_payload;
  logic [XLEN-1:0]      ds_rj_value;
  logic [XLEN-1:0]      ds_rk_value;
  logic                 ds_hazard;

  modport master (
    output fs_valid, fs_payload, fs_rj, fs_rk, fs_use_rj, fs_use_rk,
    output rf_rdata1, rf_rdata2,
    output es_fwd_valid, es_fwd_dest, es_fwd_is_load, es_fwd_data,
    output ms_fwd_valid, ms_fwd_dest, ms_fwd_data_ok, ms_fwd_data,
    output ws_fwd_valid, ws_fwd_dest, ws_fwd_data,
    output es_allow_in, flush,
    input  ds_allow_in, rf_raddr1, rf_raddr2,
    input  ds_to_es_valid, ds_payload, ds_rj_value, ds_rk_value, ds_hazard
  );

  modport slave (
    input  fs_valid, fs_payload, fs_rj, fs_rk, fs_use_rj, fs_use_rk,
    input  rf_rdata1, rf_rdata2,
    input  es_fwd_valid, es_fwd_dest, es_fwd_is_load, es_fwd_data,
    input  ms_fwd_valid, ms_fwd_dest, ms_fwd_data_ok, ms_fwd_data,
    input  ws_fwd_valid, ws_fwd_dest, ws_fwd_data,
    input  es_allow_in, flush,
    output ds_allow_in, rf_raddr1, rf_raddr2,
    output ds_to_es_valid, ds_payload, ds_rj_value, ds_rk_value, ds_hazard
  );
endinterface
`default_nettype wire

// File: rtl/ds_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ds_operand_stage
// Brief    : Decode/operand-read pipeline stage. Holds one instruction in a
//            valid/allow-in register, reads rj/rk from the regfile, forwards
//            from EX/MEM/WB (nearest wins) and interlocks on load-use or on
//            MEM data that is not ready yet. Synchronous flush squashes the
//            held instruction.
//            Optional macro DS_STALL_CNT_EN adds a saturating stall_cycles
//            counter output.
// Revision : 1.0 - initial release
// ============================================================================
module ds_operand_stage #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int PAYLOAD_W = 64
) (
  input  logic               clk,
  input  logic               rst,
`ifdef DS_STALL_CNT_EN
  output logic [31:0]        stall_cycles,
`endif
  ds_operand_stage_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  // Held instruction state
  logic                 ds_valid_q,   ds_valid_d;
  logic [PAYLOAD_W-1:0] payload_q,    payload_d;
  logic [AW-1:0]        rj_q,         rj_d;
  logic [AW-1:0]        rk_q,         rk_d;
  logic                 use_rj_q,     use_rj_d;
  logic                 use_rk_q,     use_rk_d;

  // Operand resolution results
  logic                 rj_hazard;
  logic                 rk_hazard;
  logic [XLEN-1:0]      rj_value;
  logic [XLEN-1:0]      rk_value;
  logic                 ds_ready_go;
  logic                 ds_allow_in;
  logic                 ds_hazard;

  // Returns {hazard, value} for one source. Register 0 is hard-wired to zero
  // and never participates in forwarding. A source whose use flag is low
  // simply shows the regfile data and can never stall.
  function automatic logic [XLEN:0] resolve_src(
    input logic [AW-1:0]   src,
    input logic            use_src,
    input logic [XLEN-1:0] rf_data,
    input logic            es_v,
    input logic [AW-1:0]   es_dst,
    input logic            es_ld,
    input logic [XLEN-1:0] es_dat,
    input logic            ms_v,
    input logic [AW-1:0]   ms_dst,
    input logic            ms_ok,
    input logic [XLEN-1:0] ms_dat,
    input logic            ws_v,
    input logic [AW-1:0]   ws_dst,
    input logic [XLEN-1:0] ws_dat
  );
    logic live;
    live = use_src && (src != '0);
    if (src == '0) begin
      return {1'b0, {XLEN{1'b0}}};
    end else if (live && es_v && (es_dst == src)) begin
      // A load in EX has no data yet: interlock instead of forwarding.
      return es_ld ? {1'b1, {XLEN{1'b0}}} : {1'b0, es_dat};
    end else if (live && ms_v && (ms_dst == src)) begin
      return ms_ok ? {1'b0, ms_dat} : {1'b1, {XLEN{1'b0}}};
    end else if (live && ws_v && (ws_dst == src)) begin
      return {1'b0, ws_dat};
    end else begin
      return {1'b0, rf_data};
    end
  endfunction

  // Resolve both operands every cycle so a stalled instruction sees fresh
  // forwarding data as soon as the producing stage has it.
  always_comb begin
    {rj_hazard, rj_value} = resolve_src(
      rj_q, use_rj_q, bus.rf_rdata1,
      bus.es_fwd_valid, bus.es_fwd_dest, bus.es_fwd_is_load, bus.es_fwd_data,
      bus.ms_fwd_valid, bus.ms_fwd_dest, bus.ms_fwd_data_ok, bus.ms_fwd_data,
      bus.ws_fwd_valid, bus.ws_fwd_dest, bus.ws_fwd_data);
    {rk_hazard, rk_value} = resolve_src(
      rk_q, use_rk_q, bus.rf_rdata2,
      bus.es_fwd_valid, bus.es_fwd_dest, bus.es_fwd_is_load, bus.es_fwd_data,
      bus.ms_fwd_valid, bus.ms_fwd_dest, bus.ms_fwd_data_ok, bus.ms_fwd_data,
      bus.ws_fwd_valid, bus.ws_fwd_dest, bus.ws_fwd_data);
  end

  assign ds_ready_go = !(rj_hazard || rk_hazard);
  assign ds_hazard   = ds_valid_q && !ds_ready_go;
  assign ds_allow_in = !ds_valid_q || (ds_ready_go && bus.es_allow_in);

  assign bus.ds_allow_in    = ds_allow_in;
  assign bus.ds_hazard      = ds_hazard;
  assign bus.ds_to_es_valid = ds_valid_q && ds_ready_go && !bus.flush;
  assign bus.ds_payload     = payload_q;
  assign bus.ds_rj_value    = rj_value;
  assign bus.ds_rk_value    = rk_value;
  assign bus.rf_raddr1      = rj_q;
  assign bus.rf_raddr2      = rk_q;

  // Next-state for the instruction register: flush wins, otherwise accept
  // when there is room; bus fields only change on an actual capture.
  always_comb begin
    ds_valid_d = ds_valid_q;
    payload_d  = payload_q;
    rj_d       = rj_q;
    rk_d       = rk_q;
    use_rj_d   = use_rj_q;
    use_rk_d   = use_rk_q;
    if (bus.flush) begin
      ds_valid_d = 1'b0;
    end else if (ds_allow_in) begin
      ds_valid_d = bus.fs_valid;
      if (bus.fs_valid) begin
        payload_d = bus.fs_payload;
        rj_d      = bus.fs_rj;
        rk_d      = bus.fs_rk;
        use_rj_d  = bus.fs_use_rj;
        use_rk_d  = bus.fs_use_rk;
      end
    end
  end

  // Instruction register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ds_valid_q <= 1'b0;
      payload_q  <= '0;
      rj_q       <= '0;
      rk_q       <= '0;
      use_rj_q   <= 1'b0;
      use_rk_q   <= 1'b0;
    end else begin
      ds_valid_q <= ds_valid_d;
      payload_q  <= payload_d;
      rj_q       <= rj_d;
      rk_q       <= rk_d;
      use_rj_q   <= use_rj_d;
      use_rk_q   <= use_rk_d;
    end
  end

`ifdef DS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count stalled edges that are not being flushed; stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ds_hazard && !bus.flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ds_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_operand_stage
// Brief    : Self-checking bench for ds_operand_stage: directed scenarios
//            followed by randomized traffic against a behavioural model.
//            Build with DS_STALL_CNT_EN defined to also cover stall_cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ds_operand_stage;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int PW   = 64;
  localparam int AW   = $clog2(NREG);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ds_operand_stage_if #(.XLEN(XLEN), .NREG(NREG), .PAYLOAD_W(PW)) bus ();

`ifdef DS_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  ds_operand_stage #(.XLEN(XLEN), .NREG(NREG), .PAYLOAD_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef DS_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model of the single instruction slot
  logic            m_valid = 1'b0;
  logic [PW-1:0]   m_payload = '0;
  logic [AW-1:0]   m_rj = '0, m_rk = '0;
  logic            m_use_rj = 1'b0, m_use_rk = 1'b0;
  logic [31:0]     m_stall = '0;

  // Predictions for the current cycle
  logic            e_ready, e_haz, e_allow, e_to_es;
  logic [XLEN-1:0] e_vj, e_vk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk the producer list nearest-first; the first producer writing this
  // register decides: blocked producers stall, others supply their data.
  function automatic void ref_resolve(input logic [AW-1:0] idx, input logic use_s,
                                      input logic [XLEN-1:0] rf,
                                      output logic haz, output logic [XLEN-1:0] val);
    logic            v[3];
    logic [AW-1:0]   d[3];
    logic [XLEN-1:0] x[3];
    logic            blk[3];
    v[0] = bus.es_fwd_valid; d[0] = bus.es_fwd_dest; x[0] = bus.es_fwd_data; blk[0] = bus.es_fwd_is_load;
    v[1] = bus.ms_fwd_valid; d[1] = bus.ms_fwd_dest; x[1] = bus.ms_fwd_data; blk[1] = !bus.ms_fwd_data_ok;
    v[2] = bus.ws_fwd_valid; d[2] = bus.ws_fwd_dest; x[2] = bus.ws_fwd_data; blk[2] = 1'b0;
    haz = 1'b0;
    val = rf;
    if (idx == 0) begin
      val = '0;
      return;
    end
    if (!use_s) return;
    for (int k = 0; k < 3; k++) begin
      if (v[k] && d[k] == idx) begin
        haz = blk[k];
        if (!blk[k]) val = x[k];
        return;
      end
    end
  endfunction

  task automatic predict();
    logic hj, hk;
    ref_resolve(m_rj, m_use_rj, bus.rf_rdata1, hj, e_vj);
    ref_resolve(m_rk, m_use_rk, bus.rf_rdata2, hk, e_vk);
    e_ready = !(hj || hk);
    e_haz   = m_valid && !e_ready;
    e_allow = !m_valid || (e_ready && bus.es_allow_in);
    e_to_es = m_valid && e_ready && !bus.flush;
  endtask

  task automatic check_all();
    predict();
    check("allow_in",   64'(bus.ds_allow_in),    64'(e_allow));
    check("to_es",      64'(bus.ds_to_es_valid), 64'(e_to_es));
    check("hazard",     64'(bus.ds_hazard),      64'(e_haz));
    check("raddr1",     64'(bus.rf_raddr1),      64'(m_rj));
    check("raddr2",     64'(bus.rf_raddr2),      64'(m_rk));
    if (m_valid) check("payload", 64'(bus.ds_payload), 64'(m_payload));
    if (m_valid && e_ready) begin
      check("rj_value", 64'(bus.ds_rj_value), 64'(e_vj));
      check("rk_value", 64'(bus.ds_rk_value), 64'(e_vk));
    end
`ifdef DS_STALL_CNT_EN
    check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
  endtask

  // Advance one clock, moving the model with the inputs present at the edge.
  task automatic tick();
    logic          n_valid;
    logic [PW-1:0] n_payload;
    logic [AW-1:0] n_rj, n_rk;
    logic          n_urj, n_urk;
    logic [31:0]   n_stall;
    predict();
    n_valid = m_valid; n_payload = m_payload; n_rj = m_rj; n_rk = m_rk;
    n_urj = m_use_rj; n_urk = m_use_rk; n_stall = m_stall;
    if (rst) begin
      n_valid = 1'b0; n_payload = '0; n_rj = '0; n_rk = '0;
      n_urj = 1'b0; n_urk = 1'b0; n_stall = '0;
    end else begin
      if (e_haz && !bus.flush && m_stall != 32'hFFFF_FFFF) n_stall = m_stall + 1;
      if (bus.flush) n_valid = 1'b0;
      else if (e_allow) begin
        n_valid = bus.fs_valid;
        if (bus.fs_valid) begin
          n_payload = bus.fs_payload; n_rj = bus.fs_rj; n_rk = bus.fs_rk;
          n_urj = bus.fs_use_rj; n_urk = bus.fs_use_rk;
        end
      end
    end
    @(posedge clk);
    m_valid = n_valid; m_payload = n_payload; m_rj = n_rj; m_rk = n_rk;
    m_use_rj = n_urj; m_use_rk = n_urk; m_stall = n_stall;
    #1;
  endtask

  task automatic clear_fwd();
    bus.es_fwd_valid = 0; bus.es_fwd_dest = '0; bus.es_fwd_is_load = 0; bus.es_fwd_data = '0;
    bus.ms_fwd_valid = 0; bus.ms_fwd_dest = '0; bus.ms_fwd_data_ok = 0; bus.ms_fwd_data = '0;
    bus.ws_fwd_valid = 0; bus.ws_fwd_dest = '0; bus.ws_fwd_data = '0;
  endtask

  task automatic fetch(input logic [AW-1:0] rj, input logic urj,
                       input logic [AW-1:0] rk, input logic urk);
    bus.fs_valid = 1; bus.fs_rj = rj; bus.fs_use_rj = urj;
    bus.fs_rk = rk; bus.fs_use_rk = urk;
    bus.fs_payload = {$urandom(), $urandom()};
  endtask

  initial begin
    rst = 1;
    bus.fs_valid = 0; bus.fs_payload = '0; bus.fs_rj = '0; bus.fs_rk = '0;
    bus.fs_use_rj = 0; bus.fs_use_rk = 0;
    bus.rf_rdata1 = '0; bus.rf_rdata2 = '0;
    bus.es_allow_in = 1; bus.flush = 0;
    clear_fwd();
    @(posedge clk); #1;

    // Reset state
    @(negedge clk); check_all();
    check("rst_allow_in", 64'(bus.ds_allow_in), 64'd1);
    check("rst_to_es",    64'(bus.ds_to_es_valid), 64'd0);
    check("rst_hazard",   64'(bus.ds_hazard), 64'd0);
    tick(); rst = 0;

    // No hazard: one-cycle latency, regfile operands
    fetch(3, 1, 4, 1); bus.rf_rdata1 = 32'h11; bus.rf_rdata2 = 32'h22;
    @(negedge clk); check_all(); tick();
    bus.fs_valid = 0;
    @(negedge clk); check_all();
    check("nohaz_to_es", 64'(bus.ds_to_es_valid), 64'd1);
    check("nohaz_rj",    64'(bus.ds_rj_value), 64'h11);
    check("nohaz_rk",    64'(bus.ds_rk_value), 64'h22);
    check("nohaz_haz",   64'(bus.ds_hazard), 64'd0);
    tick();

    // Priority: ES over MS over WS
    fetch(5, 1, 0, 0);
    @(negedge clk); check_all(); tick();
    bus.fs_valid = 0; bus.es_allow_in = 0;
    bus.es_fwd_valid = 1; bus.es_fwd_dest = 5; bus.es_fwd_data = 32'hA;
    bus.ms_fwd_valid = 1; bus.ms_fwd_dest = 5; bus.ms_fwd_data = 32'hB; bus.ms_fwd_data_ok = 1;
    bus.ws_fwd_valid = 1; bus.ws_fwd_dest = 5; bus.ws_fwd_data = 32'hC;
    @(negedge clk); check_all(); check("prio_es", 64'(bus.ds_rj_value), 64'hA);
    bus.es_fwd_valid = 0;
    #1; check_all(); check("prio_ms", 64'(bus.ds_rj_value), 64'hB);
    bus.ms_fwd_valid = 0;
    #1; check_all(); check("prio_ws", 64'(bus.ds_rj_value), 64'hC);
    tick();
    bus.es_allow_in = 1; clear_fwd();

    // Load-use interlock, then MS forwards the loaded data
    fetch(0, 0, 7, 1);
    @(negedge clk); check_all(); tick();
    bus.fs_valid = 0;
    bus.es_fwd_valid = 1; bus.es_fwd_dest = 7; bus.es_fwd_is_load = 1;
    @(negedge clk); check_all();
    check("ldu_haz",   64'(bus.ds_hazard), 64'd1);
    check("ldu_allow", 64'(bus.ds_allow_in), 64'd0);
    tick();
    clear_fwd();
    bus.ms_fwd_valid = 1; bus.ms_fwd_dest = 7; bus.ms_fwd_data_ok = 1; bus.ms_fwd_data = 32'h55;
    @(negedge clk); check_all();
    check("ldu_rk",    64'(bus.ds_rk_value), 64'h55);
    check("ldu_to_es", 64'(bus.ds_to_es_valid), 64'd1);
    tick(); clear_fwd();

    // Register 0 never stalls and reads zero
    fetch(0, 1, 0, 0); bus.rf_rdata1 = 32'h99;
    bus.es_fwd_valid = 1; bus.es_fwd_dest = 0; bus.es_fwd_is_load = 1;
    tick(); bus.fs_valid = 0;
    @(negedge clk); check_all();
    check("r0_haz",   64'(bus.ds_hazard), 64'd0);
    check("r0_val",   64'(bus.ds_rj_value), 64'd0);
    check("r0_to_es", 64'(bus.ds_to_es_valid), 64'd1);
    tick(); clear_fwd();

    // Flush while stalled on MS data not ready
    fetch(9, 1, 0, 0);
    tick(); bus.fs_valid = 0;
    bus.ms_fwd_valid = 1; bus.ms_fwd_dest = 9; bus.ms_fwd_data_ok = 0;
    @(negedge clk); check_all(); check("fl_haz", 64'(bus.ds_hazard), 64'd1);
    bus.flush = 1;
    #1; check_all(); check("fl_to_es", 64'(bus.ds_to_es_valid), 64'd0);
    tick(); bus.flush = 0; clear_fwd();
    @(negedge clk); check_all();
    check("fl_gone_allow", 64'(bus.ds_allow_in), 64'd1);
    check("fl_gone_to_es", 64'(bus.ds_to_es_valid), 64'd0);

    // Flush together with an incoming instruction discards it
    fetch(3, 1, 4, 1); bus.flush = 1;
    tick(); bus.flush = 0; bus.fs_valid = 0;
    @(negedge clk); check_all(); check("flfs_to_es", 64'(bus.ds_to_es_valid), 64'd0);
    tick();

`ifdef DS_STALL_CNT_EN
    // Three-cycle MS stall counted, then cleared by reset
    rst = 1; tick(); rst = 0;
    fetch(6, 1, 0, 0);
    tick(); bus.fs_valid = 0;
    bus.ms_fwd_valid = 1; bus.ms_fwd_dest = 6; bus.ms_fwd_data_ok = 0;
    repeat (3) begin @(negedge clk); check_all(); tick(); end
    bus.ms_fwd_data_ok = 1;
    @(negedge clk); check_all();
    check("cnt_3",     64'(stall_cycles), 64'd3);
    check("cnt_to_es", 64'(bus.ds_to_es_valid), 64'd1);
    bus.es_allow_in = 0; rst = 1; tick(); rst = 0; bus.es_allow_in = 1; clear_fwd();
    @(negedge clk); check_all();
    check("cnt_rst",   64'(stall_cycles), 64'd0);
    check("cnt_rst_v", 64'(bus.ds_to_es_valid), 64'd0);
    tick();
`endif

    // Randomized traffic with a small register range to provoke matches
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(63) == 0);
      bus.fs_valid   = 1'($urandom_range(1));
      bus.fs_payload = {$urandom(), $urandom()};
      bus.fs_rj      = AW'($urandom_range(4));
      bus.fs_rk      = AW'($urandom_range(4));
      bus.fs_use_rj  = 1'($urandom_range(1));
      bus.fs_use_rk  = 1'($urandom_range(1));
      bus.rf_rdata1  = $urandom();
      bus.rf_rdata2  = $urandom();
      bus.es_fwd_valid   = 1'($urandom_range(1));
      bus.es_fwd_dest    = AW'($urandom_range(4));
      bus.es_fwd_is_load = ($urandom_range(3) == 0);
      bus.es_fwd_data    = $urandom();
      bus.ms_fwd_valid   = 1'($urandom_range(1));
      bus.ms_fwd_dest    = AW'($urandom_range(4));
      bus.ms_fwd_data_ok = ($urandom_range(3) != 0);
      bus.ms_fwd_data    = $urandom();
      bus.ws_fwd_valid   = 1'($urandom_range(1));
      bus.ws_fwd_dest    = AW'($urandom_range(4));
      bus.ws_fwd_data    = $urandom();
      bus.es_allow_in    = ($urandom_range(3) != 0);
      bus.flush          = ($urandom_range(15) == 0);
      @(negedge clk); check_all();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ds_operand_stage.md
Name: ds_operand_stage

Overview:
- Parametrised decode/operand-read pipeline stage. It sits between the fetch stage and the execute stage.
- Holds one instruction in a valid/allow-in handshake register and reads two source registers from the regfile.
- Resolves RAW hazards by forwarding from the EX, MEM and WB stages, and interlocks (holds) on load-use or on MEM data that is not yet ready.
- Supports a synchronous flush for branch redirect. Successor to the fixed 32-bit decode stage that had no forwarding (ready_go tied high).

Parameters:
- XLEN, 32, datapath width of operands and forwarded results.
- NREG, 32, number of architectural registers; AW = $clog2(NREG) is the register-index width.
- PAYLOAD_W, 64, width of the opaque pass-through bus ({pc, inst} by default).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- fs_valid  in  1  upstream holds a valid instruction
- ds_allow_in  out  1  this stage can accept a new instruction this cycle
- fs_payload  in  PAYLOAD_W  pass-through bus captured with the instruction
- fs_rj / fs_rk  in  AW each  source register indices
- fs_use_rj / fs_use_rk  in  1 each  source is actually read by the instruction
- rf_raddr1 / rf_raddr2  out  AW each  regfile read addresses (registered rj / rk)
- rf_rdata1 / rf_rdata2  in  XLEN each  regfile read data
- es_fwd_valid, es_fwd_dest[AW], es_fwd_is_load, es_fwd_data[XLEN]  in  EX-stage forward source
- ms_fwd_valid, ms_fwd_dest[AW], ms_fwd_data_ok, ms_fwd_data[XLEN]  in  MEM-stage forward source
- ws_fwd_valid, ws_fwd_dest[AW], ws_fwd_data[XLEN]  in  WB-stage forward source (writeback)
- es_allow_in  in  1  downstream can accept
- flush  in  1  branch redirect; squash the held instruction
- ds_to_es_valid  out  1  output instruction valid
- ds_payload  out  PAYLOAD_W  registered payload
- ds_rj_value / ds_rk_value  out  XLEN each  resolved operands
- ds_hazard  out  1  high while the stage is stalled on a hazard

Behaviour:
Interface:
- reset rst, synchronous, active-high; clock clk.
- On reset: ds_valid=0; payload, rj, rk and the use flags are cleared to 0. Therefore ds_to_es_valid=0, ds_hazard=0 and ds_allow_in=1 after reset.

Handshake:
- ds_allow_in = !ds_valid | (ds_ready_go & es_allow_in).
- ds_to_es_valid = ds_valid & ds_ready_go & !flush.
- On a clock edge, flush has highest priority and sets ds_valid to 0.
- Otherwise, if ds_allow_in, ds_valid takes fs_valid, and the bus registers load only when fs_valid=1.
- Latency is 1 cycle when no hazard exists.

Forwarding match (per source S in {rj, rk}):
- A stage X matches S when: use_S, S != 0, X_fwd_valid, and X_fwd_dest == S.
- Register 0 always reads 0 and is never forwarded or interlocked.

Priority:
- ES match gives es_fwd_data, unless es_fwd_is_load, which is a hazard.
- Else MS match gives ms_fwd_data if ms_fwd_data_ok, else a hazard.
- Else WS match gives ws_fwd_data.
- Else the regfile data.
- The nearest stage always wins when several stages match.

Stall:
- ds_ready_go = !(hazard on rj | hazard on rk). ds_hazard = ds_valid & !ds_ready_go.
- While stalled, all state is held. Forwarded values are recomputed combinationally every cycle. No stall-duration limit.

Corner cases:
- Flush during a stall drops the instruction; the next edge gives ds_valid=0.
- Flush together with fs_valid: the incoming instruction is discarded.
- A source with its use flag low never causes a hazard.

Optional Feature:
- Macro DS_STALL_CNT_EN.
- When defined: add output port stall_cycles [31:0]. It resets to 0, increments on each edge where ds_hazard=1 and flush=0, and saturates at 32'hFFFF_FFFF.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- No hazard: rj=3, rk=4 with rf data 0x11, 0x22 and all fwd_valid=0 -> ds_to_es_valid one cycle after capture; outputs 0x11, 0x22; ds_hazard=0.
- Priority: rj=5 matched in ES (data 0xA), MS (0xB, ok=1) and WS (0xC), not a load -> ds_rj_value=0xA. Deassert ES -> 0xB. Deassert MS -> 0xC.
- Load-use: rk=7, es_fwd_is_load=1, dest=7, es_allow_in=1 -> ds_hazard=1, ds_allow_in=0 for 1 cycle. Next cycle the load is in MS with ok=1, data 0x55 -> ds_rk_value=0x55, ds_to_es_valid=1.
- Register 0: rj=0 with ES dest=0, valid, is_load=1 -> no stall; ds_rj_value=0.
- Flush while stalled (ms_fwd_data_ok=0 match) -> ds_to_es_valid=0 in that cycle, ds_valid=0 next cycle. Flush with fs_valid=1 -> nothing is captured.
- With DS_STALL_CNT_EN: a 3-cycle MS-not-ok stall -> stall_cycles=3. Assert rst -> stall_cycles=0 and ds_valid=0.
